// File: rtl/mmio_hub_pkg.sv
// mmio_hub_pkg: shared address map and key-head field layout for mmio_hub.
package mmio_hub_pkg;

  // Load/store address map inside the 0..31 MMIO window.
  localparam logic [31:0] KEY_RD   = 32'd0;
  localparam logic [31:0] LVL_BASE = 32'd1;
  localparam logic [31:0] CNT_BASE = 32'd8;
  localparam logic [31:0] KEY_POP  = 32'd16;
  localparam logic [31:0] CNT_CLR  = 32'd17;
  localparam logic [31:0] OUT_BASE = 32'd24;
  localparam logic [31:0] MMIO_TOP = 32'd31;

  // Key-head word layout.
  localparam int KEY_NE_BIT  = 31;
  localparam int KEY_OVF_BIT = 30;
  localparam int KEY_CODE_W  = 4;

  // Packs the key-head read word; all unlisted bits are zero.
  function automatic logic [31:0] key_head(input logic nonempty,
                                           input logic overflow,
                                           input logic [KEY_CODE_W-1:0] code);
    logic [31:0] w;
    w = '0;
    w[KEY_NE_BIT]         = nonempty;
    w[KEY_OVF_BIT]        = overflow;
    w[KEY_CODE_W-1:0]     = code;
    return w;
  endfunction

endpackage

// File: rtl/mmio_sensor_chan.sv
// mmio_sensor_chan: one active-low sensor input. Synchroniser, optional
// debounce (MMIO_HUB_DEBOUNCE_EN), rising-edge detect and a saturating
// event counter with a clear input.
module mmio_sensor_chan #(
  parameter int DEBOUNCE_CYC = 30000,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sensor_n,
  input  logic             clear,
  output logic             level,
  output logic [CNT_W-1:0] count
);

  logic sync1, sync2;
  logic level_q;
  logic rise;

  // Two-flop synchroniser; inversion happens on entry so reset means "not broken".
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of its neighbours.
      sync1 <= ~sensor_n;
      sync2 <= sync1;
    end
  end

`ifdef MMIO_HUB_DEBOUNCE_EN
  localparam int STAB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic [STAB_W-1:0] stab;
  logic              deb;

  // Debounce: flip only after DEBOUNCE_CYC consecutive disagreeing samples.
  always_ff @(posedge clock) begin
    if (reset) begin
      stab <= '0;
      deb  <= 1'b0;
    end else if (sync2 == deb) begin
      stab <= '0;
    end else if (stab == STAB_W'(DEBOUNCE_CYC - 1)) begin
      deb  <= sync2;
      stab <= '0;
    end else begin
      stab <= stab + 1'b1;
    end
  end

  assign level = deb;
`else
  assign level = sync2;
`endif

  assign rise = level & ~level_q;

  // Delayed level for edge detect, and the saturating event counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      level_q <= 1'b0;
      count   <= '0;
    end else begin
      level_q <= level;
      if (clear)
        count <= rise ? CNT_W'(1) : '0;
      else if (rise && (count != {CNT_W{1'b1}}))
        count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mmio_hub.sv
// mmio_hub: MMIO decode for sensors, key FIFO and output registers, muxed
// with RAM load data. Optional debounce selected by MMIO_HUB_DEBOUNCE_EN.
module mmio_hub
  import mmio_hub_pkg::*;
#(
  parameter int NUM_IN       = 4,
  parameter int NUM_OUT      = 8,
  parameter int DEBOUNCE_CYC = 30000,
  parameter int CNT_W        = 16,
  parameter int KEY_DEPTH    = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           mem_addr,
  input  logic                  mem_we,
  input  logic [31:0]           mem_wdata,
  input  logic [31:0]           ram_rdata,
  output logic [31:0]           mem_rdata,
  input  logic [NUM_IN-1:0]     sensor_n,
  input  logic [3:0]            key_code,
  input  logic                  key_strobe,
  output logic [32*NUM_OUT-1:0] out_regs
);

  localparam int PTR_W = $clog2(KEY_DEPTH);

  logic             mmio_wr;
  logic             pop_req;
  logic             do_pop;
  logic             do_push;
  logic [NUM_IN-1:0] clr_vec;
  logic [NUM_IN-1:0] chan_lvl;
  logic [CNT_W-1:0]  chan_cnt [NUM_IN];
  logic [31:0]       out_q    [NUM_OUT];

  logic [3:0]       key_mem [KEY_DEPTH];
  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic             key_empty, key_full, key_ovf;

  assign mmio_wr = mem_we && (mem_addr <= MMIO_TOP);
  assign pop_req = mmio_wr && (mem_addr == KEY_POP);
  assign clr_vec = (mmio_wr && (mem_addr == CNT_CLR)) ? mem_wdata[NUM_IN-1:0] : '0;

  // Sensor channels.
  for (genvar i = 0; i < NUM_IN; i++) begin : g_chan
    mmio_sensor_chan #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .CNT_W       (CNT_W)
    ) u_chan (
      .clock   (clock),
      .reset   (reset),
      .sensor_n(sensor_n[i]),
      .clear   (clr_vec[i]),
      .level   (chan_lvl[i]),
      .count   (chan_cnt[i])
    );
  end

  // Key FIFO status; a full FIFO still accepts a push when a pop frees a slot.
  assign key_empty = (wr_ptr == rd_ptr);
  assign key_full  = ((wr_ptr ^ rd_ptr) == {1'b1, {PTR_W{1'b0}}});
  assign do_pop    = pop_req && !key_empty;
  assign do_push   = key_strobe && (!key_full || do_pop);

  // Key FIFO storage.
  always_ff @(posedge clock) begin
    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are valid, and leaving RAM unreset keeps it mappable to memory.
    if (do_push)
      key_mem[wr_ptr[PTR_W-1:0]] <= key_code;
  end

  // Key FIFO pointers and sticky overflow (any pop clears it).
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      key_ovf <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (pop_req)
        key_ovf <= 1'b0;
      else if (key_strobe && key_full)
        key_ovf <= 1'b1;
    end
  end

  // CPU-writable output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_OUT; i++) out_q[i] <= '0;
    end else if (mmio_wr) begin
      for (int i = 0; i < NUM_OUT; i++)
        if (mem_addr == OUT_BASE + 32'(i)) out_q[i] <= mem_wdata;
    end
  end

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_out
    assign out_regs[32*i +: 32] = out_q[i];
  end

  // Combinational load mux: RAM above the window, decoded MMIO inside it.
  always_comb begin
    // NOTE: default first so every path assigns mem_rdata and no latch forms.
    mem_rdata = '0;
    if (mem_addr > MMIO_TOP) begin
      mem_rdata = ram_rdata;
    end else if (mem_addr == KEY_RD) begin
      mem_rdata = key_head(!key_empty, key_ovf,
                           key_empty ? 4'h0 : key_mem[rd_ptr[PTR_W-1:0]]);
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (mem_addr == LVL_BASE + 32'(i)) mem_rdata = 32'(chan_lvl[i]);
        if (mem_addr == CNT_BASE + 32'(i)) mem_rdata = 32'(chan_cnt[i]);
      end
      for (int i = 0; i < NUM_OUT; i++)
        if (mem_addr == OUT_BASE + 32'(i)) mem_rdata = out_q[i];
    end
  end

endmodule

// File: tb/tb_mmio_hub.sv
// tb_mmio_hub: directed scenarios plus randomized traffic, all checked each
// cycle against a behavioural model of the hub kept in this bench.
module tb_mmio_hub;

  localparam int NUM_IN    = 4;
  localparam int NUM_OUT   = 8;
  localparam int DEB       = 8;
  localparam int CNT_W     = 2;
  localparam int KEY_DEPTH = 4;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;
`ifdef MMIO_HUB_DEBOUNCE_EN
  localparam bit DEB_ON = 1'b1;
`else
  localparam bit DEB_ON = 1'b0;
`endif
  // Cycles from the first sampling edge of a pin fall to the counter update.
  localparam int EV_LAT = DEB_ON ? DEB + 2 : 2;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [31:0]           mem_addr, mem_wdata, ram_rdata, mem_rdata;
  logic                  mem_we;
  logic [NUM_IN-1:0]     sensor_n;
  logic [3:0]            key_code;
  logic                  key_strobe;
  logic [32*NUM_OUT-1:0] out_regs;

  int n_checks = 0;
  int n_fail   = 0;

  mmio_hub #(
    .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .DEBOUNCE_CYC(DEB),
    .CNT_W(CNT_W), .KEY_DEPTH(KEY_DEPTH)
  ) dut (
    .clock(clock), .reset(reset), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .ram_rdata(ram_rdata), .mem_rdata(mem_rdata),
    .sensor_n(sensor_n), .key_code(key_code), .key_strobe(key_strobe),
    .out_regs(out_regs)
  );

  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  bit         raw_q  [NUM_IN][$];   // broken samples, newest last
  bit         used_q [NUM_IN][$];   // samples already seen by the debouncer
  bit         lvl_m  [NUM_IN];
  bit         lvl_prev_m [NUM_IN];
  int         cnt_m  [NUM_IN];
  logic [3:0] key_q  [$];
  bit         ovf_m;
  logic [31:0] out_m [NUM_OUT];

  always @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < NUM_IN; c++) begin
        raw_q[c] = {};
        raw_q[c].push_back(1'b0);
        raw_q[c].push_back(1'b0);
        used_q[c] = {};
        lvl_m[c] = 1'b0;
        lvl_prev_m[c] = 1'b0;
        cnt_m[c] = 0;
      end
      key_q = {};
      ovf_m = 1'b0;
      for (int i = 0; i < NUM_OUT; i++) out_m[i] = '0;
    end else begin
      for (int c = 0; c < NUM_IN; c++) begin
        bit inc, clr, all_diff;
        inc = lvl_m[c] && !lvl_prev_m[c];
        clr = mem_we && (mem_addr == 32'd17) && mem_wdata[c];
        if (clr) cnt_m[c] = inc ? 1 : 0;
        else if (inc && cnt_m[c] < CNT_MAX) cnt_m[c]++;
        lvl_prev_m[c] = lvl_m[c];
        raw_q[c].push_back(!sensor_n[c]);
        if (DEB_ON) begin
          used_q[c].push_back(raw_q[c][raw_q[c].size()-3]);
          if (used_q[c].size() > DEB) void'(used_q[c].pop_front());
          all_diff = (used_q[c].size() == DEB);
          foreach (used_q[c][k]) if (used_q[c][k] == lvl_m[c]) all_diff = 1'b0;
          if (all_diff) begin
            lvl_m[c] = !lvl_m[c];
            used_q[c] = {};
          end
        end else begin
          lvl_m[c] = raw_q[c][raw_q[c].size()-2];
        end
        while (raw_q[c].size() > 3) void'(raw_q[c].pop_front());
      end
      if (mem_we && mem_addr == 32'd16) begin
        if (key_q.size() > 0) void'(key_q.pop_front());
        ovf_m = 1'b0;
      end
      if (key_strobe) begin
        if (key_q.size() < KEY_DEPTH) key_q.push_back(key_code);
        else ovf_m = 1'b1;
      end
      if (mem_we && mem_addr >= 32'd24 && mem_addr < 32'(24 + NUM_OUT))
        out_m[mem_addr - 32'd24] = mem_wdata;
    end
  end

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    logic [31:0] r;
    r = '0;
    if (a > 32'd31) r = ram_rdata;
    else if (a == 32'd0) begin
      r[31] = key_q.size() > 0;
      r[30] = ovf_m;
      r[3:0] = (key_q.size() > 0) ? key_q[0] : 4'h0;
    end
    else if (a <= 32'(NUM_IN)) r = 32'(lvl_m[a - 32'd1]);
    else if (a >= 32'd8 && a < 32'(8 + NUM_IN)) r = 32'(cnt_m[a - 32'd8]);
    else if (a >= 32'd24 && a < 32'(24 + NUM_OUT)) r = out_m[a - 32'd24];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clock) begin
    if (!reset) begin
      check($sformatf("rdata@%0d", mem_addr), mem_rdata, exp_rdata(mem_addr));
      for (int i = 0; i < NUM_OUT; i++)
        check($sformatf("out_regs[%0d]", i), out_regs[32*i +: 32], out_m[i]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    mem_addr = a; mem_wdata = d; mem_we = 1'b1;
    tick(1);
    mem_we = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    mem_addr = a;
    @(negedge clock); #1;
    check(name, mem_rdata, exp);
  endtask

  task automatic strobe(input logic [3:0] code);
    key_code = code; key_strobe = 1'b1;
    tick(1);
    key_strobe = 1'b0;
  endtask

  task automatic event_pulse(input int ch);
    sensor_n[ch] = 1'b0; tick(DEB + 4);
    sensor_n[ch] = 1'b1; tick(DEB + 4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; mem_addr = '0; mem_we = 1'b0; mem_wdata = '0;
    ram_rdata = '0; sensor_n = '1; key_code = '0; key_strobe = 1'b0;
    tick(3);
    reset = 1'b0;

    // Reset state and first store.
    rd_chk("rst_key", 32'd0, 32'h0);
    rd_chk("rst_lvl", 32'd1, 32'h0);
    rd_chk("rst_cnt", 32'd8, 32'h0);
    wr(32'd24, 32'h5);
    rd_chk("out0_rb", 32'd24, 32'h5);
    check("out0_port", out_regs[31:0], 32'h5);

    // RAM passthrough; out-of-window store has no effect.
    ram_rdata = 32'hDEADBEEF;
    rd_chk("ram_rd", 32'd40, 32'hDEADBEEF);
    wr(32'd40, 32'h1234_5678);
    @(negedge clock); #1;
    for (int i = 0; i < NUM_OUT; i++)
      check($sformatf("ram_wr_out%0d", i), out_regs[32*i +: 32], (i == 0) ? 32'h5 : 32'h0);

    // Debounce: short glitch, then a long low.
    sensor_n[1] = 1'b0; tick(5);
    sensor_n[1] = 1'b1; tick(16);
    rd_chk("glitch_lvl", 32'd2, 32'h0);
    rd_chk("glitch_cnt", 32'd9, DEB_ON ? 32'h0 : 32'h1);
    sensor_n[1] = 1'b0; tick(12);
    rd_chk("long_lvl", 32'd2, 32'h1);
    rd_chk("long_cnt", 32'd9, DEB_ON ? 32'h1 : 32'h2);
    sensor_n[1] = 1'b1; tick(16);

    // Saturation, then clear coincident with an increment.
    for (int e = 0; e < 5; e++) event_pulse(0);
    rd_chk("sat_cnt", 32'd8, 32'h3);
    sensor_n[0] = 1'b0;
    tick(EV_LAT);
    wr(32'd17, 32'h1);
    rd_chk("clr_inc", 32'd8, 32'h1);
    sensor_n[0] = 1'b1; tick(16);

    // Key FIFO fill with overflow, then drain.
    for (int k = 1; k <= 5; k++) strobe(4'(k));
    rd_chk("fifo_full_ovf", 32'd0, 32'hC000_0001);
    wr(32'd16, 32'h0);
    rd_chk("fifo_pop1", 32'd0, 32'h8000_0002);
    for (int k = 0; k < 3; k++) wr(32'd16, 32'hFFFF_FFFF);
    rd_chk("fifo_empty", 32'd0, 32'h0);

    // Push and pop together on a full FIFO.
    for (int k = 6; k <= 9; k++) strobe(4'(k));
    mem_addr = 32'd16; mem_we = 1'b1; key_code = 4'hA; key_strobe = 1'b1;
    tick(1);
    mem_we = 1'b0; key_strobe = 1'b0;
    rd_chk("push_pop_full", 32'd0, 32'h8000_0007);
    for (int k = 0; k < 5; k++) wr(32'd16, 32'h0);
    rd_chk("drained", 32'd0, 32'h0);

    // Randomized traffic with one mid-run reset.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc == 2000) reset = 1'b1;
      if (cyc == 2002) reset = 1'b0;
      mem_addr   = ($urandom_range(0, 9) == 0) ? 32'(32 + $urandom_range(0, 100))
                                                : 32'($urandom_range(0, 31));
      mem_we     = ($urandom_range(0, 3) == 0);
      mem_wdata  = $urandom;
      ram_rdata  = $urandom;
      key_code   = 4'($urandom);
      key_strobe = ($urandom_range(0, 2) == 0);
      for (int c = 0; c < NUM_IN; c++)
        if ($urandom_range(0, 19) == 0) sensor_n[c] = ~sensor_n[c];
      tick(1);
    end
    mem_we = 1'b0; key_strobe = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
